// File: rtl/carrier_acq_ctrl_pkg.sv
// Shared definitions for the carrier acquisition controller: default widths,
// acquisition state codes and sweep direction codes.
package carrier_acq_ctrl_pkg;

    localparam int ERR_W_DEF  = 12;
    localparam int CNT_W_DEF  = 16;
    localparam int SWP_W_DEF  = 32;
    localparam int HOLD_W_DEF = 8;

    // Acquisition state codes; code 3 is unused and recovers to ST_TRACK.
    localparam logic [1:0] ST_TRACK = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_SWEEP = 2'd2;

    // Sweep direction.
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/carrier_acq_ctrl_if.sv
// Control/status bundle between the demod datapath and the carrier
// acquisition controller. The master drives the error samples and the
// configuration; the slave (the controller) returns lock, loop-break,
// sweep offset and status.
interface carrier_acq_ctrl_if
    import carrier_acq_ctrl_pkg::*;
#(
    parameter int ERR_W  = ERR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int SWP_W  = SWP_W_DEF,
    parameter int HOLD_W = HOLD_W_DEF
);

    logic              err_en;
    logic [ERR_W-1:0]  error;
    logic              enable_lock;
    logic              sweep_enable;
    logic [ERR_W-2:0]  threshold;
    logic [CNT_W-1:0]  lock_count;
    logic [SWP_W-1:0]  sweep_rate;
    logic [SWP_W-1:0]  sweep_limit;
    logic [HOLD_W-1:0] holdoff;

    logic              carrier_lock;
    logic              break_loop;
    logic [SWP_W-1:0]  sweep_offset;
    logic [CNT_W-1:0]  lock_counter;
    logic [1:0]        acq_state;

    modport master (
        output err_en, error, enable_lock, sweep_enable, threshold,
               lock_count, sweep_rate, sweep_limit, holdoff,
        input  carrier_lock, break_loop, sweep_offset, lock_counter, acq_state
    );

    modport slave (
        input  err_en, error, enable_lock, sweep_enable, threshold,
               lock_count, sweep_rate, sweep_limit, holdoff,
        output carrier_lock, break_loop, sweep_offset, lock_counter, acq_state
    );

endinterface

// File: rtl/carrier_acq_ctrl_lock_hyst.sv
// Lock detector: saturating error magnitude, threshold compare and a signed
// up/down hysteresis counter. lock_next is the lock value that will be
// registered on this errEn sample, so the acquisition FSM can react in the
// same cycle that carrier_lock changes.
module carrier_lock_hyst
    import carrier_acq_ctrl_pkg::*;
#(
    parameter int ERR_W = ERR_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             err_en,
    input  logic [ERR_W-1:0] error,
    input  logic             enable_lock,
    input  logic [ERR_W-2:0] threshold,
    input  logic [CNT_W-1:0] lock_count,
    output logic             lock_next,
    output logic             carrier_lock,
    output logic [CNT_W-1:0] lock_counter
);

    localparam logic signed [CNT_W:0] CNT_ONE = 1;

    logic [ERR_W-1:0]        err_neg;
    logic [ERR_W-2:0]        abs_err;
    logic                    good;
    logic signed [CNT_W:0]   cnt_ext;
    logic signed [CNT_W:0]   cnt_step;
    logic signed [CNT_W:0]   lim_pos;
    logic signed [CNT_W:0]   lim_neg;
    logic [CNT_W-1:0]        cnt_next;

    // Magnitude of the error; only the most-negative code stays negative
    // after negation, and that one saturates to full scale.
    always_comb begin
        err_neg = -error;
        if (!error[ERR_W-1]) begin
            abs_err = error[ERR_W-2:0];
        end else if (err_neg[ERR_W-1]) begin
            abs_err = '1;
        end else begin
            abs_err = err_neg[ERR_W-2:0];
        end
        good = (abs_err <= threshold);
    end

    // Next lock flag and counter; comparisons run one bit wider so that
    // +/-lock_count is always representable.
    always_comb begin
        cnt_ext   = {lock_counter[CNT_W-1], lock_counter};
        cnt_step  = good ? (cnt_ext + CNT_ONE) : (cnt_ext - CNT_ONE);
        lim_pos   = {1'b0, lock_count};
        lim_neg   = -lim_pos;
        lock_next = carrier_lock;
        cnt_next  = lock_counter;
        if (!enable_lock) begin
            lock_next = 1'b1;
            cnt_next  = '0;
        end else if (lock_count == '0) begin
            lock_next = good;
            cnt_next  = '0;
        end else if (cnt_step == lim_pos) begin
            lock_next = 1'b1;
            cnt_next  = '0;
        end else if (cnt_step == lim_neg) begin
            lock_next = 1'b0;
            cnt_next  = '0;
        end else begin
            cnt_next  = cnt_step[CNT_W-1:0];
        end
    end

    // Register lock flag and counter on each valid error sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            carrier_lock <= 1'b1;
            lock_counter <= '0;
        end else if (err_en) begin
            carrier_lock <= lock_next;
            lock_counter <= cnt_next;
        end
    end

endmodule

// File: rtl/carrier_acq_ctrl.sv
// Carrier acquisition and lock controller. Wraps the lock detector with an
// acquisition FSM (track / holdoff / sweep) and a bidirectional triangular
// sweep accumulator whose output is added to the loop filter lag path.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_TRACK | loop closed, sweep offset frozen
//   ST_HOLD  | lock lost, waiting holdoff samples before sweeping
//   ST_SWEEP | loop broken, offset ramps between +/-sweep_limit
//   (3)      | unused, recovers to ST_TRACK
module carrier_acq_ctrl
    import carrier_acq_ctrl_pkg::*;
#(
    parameter int ERR_W  = ERR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int SWP_W  = SWP_W_DEF,
    parameter int HOLD_W = HOLD_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    carrier_acq_ctrl_if.slave bus
);

    // Sweep arithmetic carries two guard bits: the sum of a signed offset
    // and an unsigned rate can exceed the offset range by up to 2^SWP_W.
    localparam int ACC_W = SWP_W + 2;
    localparam logic signed [ACC_W-1:0] LIM_MAX = {3'b000, {(SWP_W-1){1'b1}}};

    logic              lock_next;
    logic              carrier_lock;
    logic [CNT_W-1:0]  lock_counter;

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_next;
    logic              sweep_step;
    logic              sweep_dir;
    logic              dir_next;
    logic [SWP_W-1:0]  sweep_offset;
    logic [SWP_W-1:0]  off_next;
    logic              break_loop;

    logic signed [ACC_W-1:0] off_ext;
    logic signed [ACC_W-1:0] rate_ext;
    logic signed [ACC_W-1:0] lim_raw;
    logic signed [ACC_W-1:0] lim_pos;
    logic signed [ACC_W-1:0] lim_neg;
    logic signed [ACC_W-1:0] sum_up;
    logic signed [ACC_W-1:0] sum_dn;

    carrier_lock_hyst #(
        .ERR_W (ERR_W),
        .CNT_W (CNT_W)
    ) u_lock_hyst (
        .clk          (clk),
        .reset        (reset),
        .err_en       (bus.err_en),
        .error        (bus.error),
        .enable_lock  (bus.enable_lock),
        .threshold    (bus.threshold),
        .lock_count   (bus.lock_count),
        .lock_next    (lock_next),
        .carrier_lock (carrier_lock),
        .lock_counter (lock_counter)
    );

    // Acquisition next state. enable_lock and sweep_enable override the lock
    // transitions; lock level (not edge) drives TRACK->HOLD so that a loop
    // left unlocked while sweep was disabled still starts acquiring.
    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        sweep_step = 1'b0;
        if (!bus.enable_lock || !bus.sweep_enable) begin
            state_next = ST_TRACK;
            hold_next  = '0;
        end else begin
            case (state)
                ST_TRACK: begin
                    if (!lock_next) begin
                        if (bus.holdoff == '0) begin
                            state_next = ST_SWEEP;
                        end else begin
                            state_next = ST_HOLD;
                            hold_next  = bus.holdoff;
                        end
                    end
                end
                ST_HOLD: begin
                    if (lock_next) begin
                        state_next = ST_TRACK;
                        hold_next  = '0;
                    end else if (hold_cnt <= HOLD_W'(1)) begin
                        state_next = ST_SWEEP;
                        hold_next  = '0;
                    end else begin
                        hold_next  = hold_cnt - 1'b1;
                    end
                end
                ST_SWEEP: begin
                    if (lock_next) begin
                        state_next = ST_TRACK;
                    end else begin
                        sweep_step = 1'b1;
                    end
                end
                default: begin
                    state_next = ST_TRACK;
                    hold_next  = '0;
                end
            endcase
        end
    end

    // Triangular sweep step with clamp to +/-limit and direction reversal
    // on reaching the limit. Limits beyond the signed range clamp to it.
    always_comb begin
        off_ext  = {{2{sweep_offset[SWP_W-1]}}, sweep_offset};
        rate_ext = {2'b00, bus.sweep_rate};
        lim_raw  = {2'b00, bus.sweep_limit};
        lim_pos  = (lim_raw > LIM_MAX) ? LIM_MAX : lim_raw;
        lim_neg  = -lim_pos;
        sum_up   = off_ext + rate_ext;
        sum_dn   = off_ext - rate_ext;
        off_next = sweep_offset;
        dir_next = sweep_dir;
        if (sweep_dir == DIR_UP) begin
            if (sum_up >= lim_pos) begin
                off_next = lim_pos[SWP_W-1:0];
                dir_next = DIR_DOWN;
            end else begin
                off_next = sum_up[SWP_W-1:0];
            end
        end else begin
            if (sum_dn <= lim_neg) begin
                off_next = lim_neg[SWP_W-1:0];
                dir_next = DIR_UP;
            end else begin
                off_next = sum_dn[SWP_W-1:0];
            end
        end
    end

    // FSM, holdoff counter and sweep accumulator, advanced on errEn only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_TRACK;
            hold_cnt     <= '0;
            sweep_dir    <= DIR_UP;
            sweep_offset <= '0;
            break_loop   <= 1'b0;
        end else if (bus.err_en) begin
            state      <= state_next;
            hold_cnt   <= hold_next;
            break_loop <= (state_next == ST_SWEEP);
            if (!bus.enable_lock) begin
                sweep_offset <= '0;
                sweep_dir    <= DIR_UP;
            end else if (sweep_step) begin
                sweep_offset <= off_next;
                sweep_dir    <= dir_next;
            end
        end
    end

    assign bus.carrier_lock = carrier_lock;
    assign bus.lock_counter = lock_counter;
    assign bus.acq_state    = state;
    assign bus.sweep_offset = sweep_offset;
    assign bus.break_loop   = break_loop;

endmodule
